// File: rtl/fixed_point_pkg.sv
// fixed_point_pkg: shared <1.6> fixed-point constants and the multiplier FSM encoding
package fixed_point_pkg;
  localparam int FX_WIDTH = 8;
  localparam int FX_FRAC = 6;
  localparam logic signed [FX_WIDTH-1:0] FX_MAX = 8'sh7F;
  localparam logic signed [FX_WIDTH-1:0] FX_MIN = 8'sh80;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    SAT   = 2'd2,
    OUT   = 2'd3
  } state_t;
endpackage

// File: rtl/multiply_by_three_if.sv
// multiply_by_three_if: operand-in / product-out valid-ready handshake bundle
interface multiply_by_three_if;
  import fixed_point_pkg::*;
  logic in_valid;
  logic in_ready;
  logic [FX_WIDTH-1:0] operand;
  logic out_valid;
  logic out_ready;
  logic [FX_WIDTH-1:0] product;
  logic overflow;
  modport master (output in_valid, operand, out_ready, input in_ready, out_valid, product, overflow);
  modport slave (input in_valid, operand, out_ready, output in_ready, out_valid, product, overflow);
endinterface

// File: rtl/fx_saturate.sv
// fx_saturate: clamp a wide signed value into the <1.6> range with an overflow flag
module fx_saturate
  import fixed_point_pkg::*;
#(
  parameter int IW = 11
) (
  input  logic signed [IW-1:0]       value,
  output logic signed [FX_WIDTH-1:0] sat,
  output logic                       ovf
);
  localparam logic signed [IW-1:0] HI = IW'(FX_MAX);
  localparam logic signed [IW-1:0] LO = IW'(FX_MIN);
  // pick the rail when out of range, otherwise the exact low bits
  always_comb begin
    ovf = (value > HI) || (value < LO);
    sat = value > HI ? FX_MAX : value < LO ? FX_MIN : value[FX_WIDTH-1:0];
  end
endmodule

// File: rtl/multiply_by_three.sv
// multiply_by_three: shift-and-add multiply of a <1.6> operand by constant K with saturation
module multiply_by_three
  import fixed_point_pkg::*;
#(
  parameter int unsigned K = 3,
  parameter int unsigned KBITS = 2
) (
  input logic clk,
  input logic rst,
  multiply_by_three_if.slave bus
);
  localparam int AW = FX_WIDTH + KBITS + 1;
  localparam logic [3:0] KV = 4'(K);
  state_t state;
  logic signed [FX_WIDTH-1:0] op_r;
  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] opx;
  logic [1:0] idx;
  logic signed [FX_WIDTH-1:0] sat;
  logic ovf;
  assign opx = AW'(op_r);
  assign bus.in_ready = state == IDLE;
  assign bus.out_valid = state == OUT;
  fx_saturate #(.IW(AW)) u_sat (.value(acc), .sat(sat), .ovf(ovf));
  // control FSM: accept, accumulate one multiplier bit per cycle, clamp, hold until drained
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      op_r <= '0;
      acc <= '0;
      idx <= '0;
      bus.product <= '0;
      bus.overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          op_r <= bus.operand;
          acc <= '0;
          idx <= '0;
          state <= ACCUM;
        end
        ACCUM: begin
          if (KV[idx]) acc <= acc + (opx <<< idx);
          idx <= idx + 2'd1;
          if (idx == 2'(KBITS - 1)) state <= SAT;
        end
        SAT: begin
          bus.product <= sat;
          bus.overflow <= ovf;
          state <= OUT;
        end
        OUT: if (bus.out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_multiply_by_three.sv
// tb_multiply_by_three: directed and exhaustive checks of the K=3 saturating multiplier
module tb_multiply_by_three;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  multiply_by_three_if bus ();
  multiply_by_three #(.K(3), .KBITS(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic do_op(input logic [7:0] op, output logic [7:0] p, output logic o, output int lat);
    int t;
    t = 0;
    while (!bus.in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    bus.in_valid = 1'b1;
    bus.operand = op;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.operand = ~op;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    p = bus.product;
    o = bus.overflow;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask
  function automatic logic [8:0] model(input logic [7:0] op);
    int v;
    v = int'(signed'(op)) * 3;
    return v > 127 ? {1'b1, 8'h7F} : v < -128 ? {1'b1, 8'h80} : {1'b0, 8'(v)};
  endfunction
  typedef struct { logic [7:0] op; logic [7:0] p; logic o; } vec_t;
  vec_t vecs [12] = '{
    '{8'h10, 8'h30, 1'b0}, '{8'h30, 8'h7F, 1'b1}, '{8'h20, 8'h60, 1'b0},
    '{8'hE0, 8'hA0, 1'b0}, '{8'hC0, 8'h80, 1'b1}, '{8'h80, 8'h80, 1'b1},
    '{8'h00, 8'h00, 1'b0}, '{8'hFF, 8'hFD, 1'b0}, '{8'h2A, 8'h7E, 1'b0},
    '{8'h2B, 8'h7F, 1'b1}, '{8'hD5, 8'h80, 1'b1}, '{8'hD6, 8'h82, 1'b0}
  };
  initial begin
    #1ms;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    logic [7:0] p;
    logic o;
    logic [8:0] m;
    int lat;
    int sweep_bad;
    bus.in_valid = 1'b0;
    bus.operand = 8'h00;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_in_ready", bus.in_ready, 1);
    chk("reset_out_valid", bus.out_valid, 0);
    chk("reset_product", bus.product, 8'h00);
    chk("reset_overflow", bus.overflow, 0);
    rst = 1'b0;
    @(negedge clk);
    do_op(8'h10, p, o, lat);
    chk("latency_edges", lat, 3);
    chk("first_product", p, 8'h30);
    chk("first_overflow", o, 0);
    foreach (vecs[i]) begin
      do_op(vecs[i].op, p, o, lat);
      chk($sformatf("vec_%02h_product", vecs[i].op), p, vecs[i].p);
      chk($sformatf("vec_%02h_overflow", vecs[i].op), o, vecs[i].o);
    end
    bus.in_valid = 1'b1;
    bus.operand = 8'h10;
    @(negedge clk);
    bus.operand = 8'h55;
    repeat (3) @(negedge clk);
    chk("bp_out_valid", bus.out_valid, 1);
    for (int c = 0; c < 5; c++) begin
      bus.operand = 8'(c * 37 + 1);
      @(negedge clk);
      chk($sformatf("bp_product_%0d", c), bus.product, 8'h30);
      chk($sformatf("bp_in_ready_%0d", c), bus.in_ready, 0);
    end
    bus.operand = 8'h20;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("drain_no_accept", bus.in_ready, 1);
    chk("drain_out_valid", bus.out_valid, 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("next_accepted", bus.in_ready, 0);
    repeat (3) @(negedge clk);
    chk("next_out_valid", bus.out_valid, 1);
    chk("next_product", bus.product, 8'h60);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.operand = 8'h30;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_accum_out_valid", bus.out_valid, 0);
    chk("rst_accum_in_ready", bus.in_ready, 1);
    chk("rst_accum_product", bus.product, 8'h00);
    do_op(8'h10, p, o, lat);
    chk("after_rst_product", p, 8'h30);
    bus.in_valid = 1'b1;
    bus.operand = 8'hC0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_out_pending", bus.out_valid, 1);
    rst = 1'b1;
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b0;
    chk("rst_out_discard_valid", bus.out_valid, 0);
    chk("rst_out_discard_ovf", bus.overflow, 0);
    chk("rst_priority_in_ready", bus.in_ready, 1);
    sweep_bad = 0;
    for (int v = 0; v < 256; v++) begin
      do_op(8'(v), p, o, lat);
      m = model(8'(v));
      if ({o, p} !== m) begin
        sweep_bad++;
        chk($sformatf("sweep_%02h", v), {23'd0, o, p}, {23'd0, m});
      end
    end
    chk("sweep_mismatches", sweep_bad, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
